// File: rtl/tracking_scoreboard_pkg.sv
// Shared types and width helpers for the tracking scoreboard.
// Widths are derived here so the top, sub-module and interface stay consistent.
package tracking_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Stage index width, wide enough to also encode "retired" (== nstages).
    function automatic int ts_width(input int nstages);
        return $clog2(nstages) + 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tracking_scoreboard_if.sv
// Handshake/observation bundle between a FIFO chain environment and the scoreboard.
// The environment drives the master side; the scoreboard is the slave.
interface tracking_scoreboard_if #(
    parameter int WIDTH   = 8,
    parameter int NSTAGES = 2,
    parameter int TSW     = tracking_pkg::ts_width(NSTAGES)
) ();

    logic               start;
    logic               push;
    logic [NSTAGES-1:0] pop;
    logic [WIDTH-1:0]   data_in;
    logic [WIDTH-1:0]   data_out;
    logic [NSTAGES-1:0] stage_empty;
    logic [NSTAGES-1:0] stage_full;
    logic [TSW-1:0]     tracked_stage;
    logic               busy;
    logic               prop_signal;
    logic               err_overflow;
    logic               err_underflow;

    modport master (
        output start, push, pop, data_in, data_out,
        input  stage_empty, stage_full, tracked_stage, busy,
               prop_signal, err_overflow, err_underflow
    );

    modport slave (
        input  start, push, pop, data_in, data_out,
        output stage_empty, stage_full, tracked_stage, busy,
               prop_signal, err_overflow, err_underflow
    );

endinterface

// File: rtl/tracking_scoreboard_stage.sv
// One FIFO stage modelled as an occupancy counter; illegal pushes/pops are dropped and flagged.
// A pop only takes effect when the downstream stage has room (i_dn_space), so occupancy never wraps.
module stage_occupancy #(
    parameter int DEPTH = 4,
    parameter int CNTW  = tracking_pkg::cnt_width(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_in_req,
    input  logic            i_pop_req,
    input  logic            i_dn_space,
    output logic [CNTW-1:0] o_occ,
    output logic            o_empty,
    output logic            o_full,
    output logic            o_space,
    output logic            o_epop,
    output logic            o_ovf,
    output logic            o_udf
);

    logic [CNTW-1:0] r_occ;
    logic            w_accept;

    assign o_occ    = r_occ;
    assign o_empty  = (r_occ == '0);
    assign o_full   = (r_occ == CNTW'(DEPTH));
    assign o_epop   = i_pop_req && !o_empty && i_dn_space;
    // A full stage still has room this cycle if its head leaves at the same time.
    assign o_space  = !o_full || o_epop;
    assign w_accept = i_in_req && o_space;
    assign o_ovf    = i_in_req && !o_space;
    assign o_udf    = i_pop_req && o_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ <= '0;
        end else begin
            case ({w_accept, o_epop})
                2'b10:   r_occ <= r_occ + CNTW'(1);
                2'b01:   r_occ <= r_occ - CNTW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: rtl/tracking_scoreboard.sv
// End-to-end checker for an NSTAGES chain of DEPTH-deep FIFOs: follows one tagged word to the exit.
// prop_signal drops combinationally in the retiring cycle if the word leaving differs from the tag.
module tracking_scoreboard
    import tracking_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int NSTAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    tracking_scoreboard_if.slave  bus
);

    localparam int CNTW = cnt_width(DEPTH);
    localparam int TSW  = ts_width(NSTAGES);

    logic [NSTAGES-1:0][CNTW-1:0] w_occ;
    logic [NSTAGES-1:0]           w_empty;
    logic [NSTAGES-1:0]           w_full;
    logic [NSTAGES-1:0]           w_epop;
    logic [NSTAGES-1:0]           w_ovf;
    logic [NSTAGES-1:0]           w_udf;
    logic [NSTAGES-1:0]           w_in_req;
    logic [NSTAGES:0]             w_space;

    state_t           r_state, w_nxt_state;
    logic [WIDTH-1:0] r_tag, w_nxt_tag;
    logic [TSW-1:0]   r_ts, w_nxt_ts;
    logic [CNTW-1:0]  r_ahead, w_nxt_ahead;
    logic             r_err_ovf, r_err_udf;

    logic             w_cur_epop;
    logic             w_at_last;
    logic [CNTW-1:0]  w_next_ahead;
    logic             w_push_ok;

    // The last stage retires to data_out, which always has room.
    assign w_space[NSTAGES] = 1'b1;

    for (genvar i = 0; i < NSTAGES; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign w_in_req[i] = bus.push;
        end else begin : g_chain
            assign w_in_req[i] = bus.pop[i-1] && !w_empty[i-1];
        end

        stage_occupancy #(
            .DEPTH (DEPTH),
            .CNTW  (CNTW)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .i_in_req   (w_in_req[i]),
            .i_pop_req  (bus.pop[i]),
            .i_dn_space (w_space[i+1]),
            .o_occ      (w_occ[i]),
            .o_empty    (w_empty[i]),
            .o_full     (w_full[i]),
            .o_space    (w_space[i]),
            .o_epop     (w_epop[i]),
            .o_ovf      (w_ovf[i]),
            .o_udf      (w_udf[i])
        );
    end

    assign w_push_ok = bus.push && w_space[0];
    assign w_at_last = (r_ts == TSW'(NSTAGES - 1));

    // Select the current stage's pop and the occupancy of the stage the tag would move into.
    always_comb begin
        w_cur_epop   = 1'b0;
        w_next_ahead = '0;
        for (int s = 0; s < NSTAGES; s++) begin
            if (r_ts == TSW'(s)) begin
                w_cur_epop = w_epop[s];
            end
            if (s > 0 && r_ts == TSW'(s - 1)) begin
                w_next_ahead = w_occ[s] - CNTW'(w_epop[s]);
            end
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_tag   = r_tag;
        w_nxt_ts    = r_ts;
        w_nxt_ahead = r_ahead;
        case (r_state)
            IDLE: begin
                if (bus.start && w_push_ok) begin
                    w_nxt_state = TRACK;
                    w_nxt_tag   = bus.data_in;
                    w_nxt_ts    = '0;
                    w_nxt_ahead = w_occ[0] - CNTW'(w_epop[0]);
                end
            end
            TRACK: begin
                if (w_cur_epop) begin
                    if (r_ahead != '0) begin
                        w_nxt_ahead = r_ahead - CNTW'(1);
                    end else if (!w_at_last) begin
                        w_nxt_ts    = r_ts + TSW'(1);
                        w_nxt_ahead = w_next_ahead;
                    end else begin
                        w_nxt_state = DONE;
                        w_nxt_ts    = TSW'(NSTAGES);
                    end
                end
            end
            DONE: begin
                w_nxt_state = DONE;
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_tag     <= '0;
            r_ts      <= '0;
            r_ahead   <= '0;
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_tag     <= w_nxt_tag;
            r_ts      <= w_nxt_ts;
            r_ahead   <= w_nxt_ahead;
            r_err_ovf <= r_err_ovf | (|w_ovf);
            r_err_udf <= r_err_udf | (|w_udf);
        end
    end

    assign bus.stage_empty   = w_empty;
    assign bus.stage_full    = w_full;
    assign bus.tracked_stage = r_ts;
    assign bus.busy          = (r_state == TRACK);
    assign bus.err_overflow  = r_err_ovf;
    assign bus.err_underflow = r_err_udf;
    assign bus.prop_signal   = !((r_state == TRACK) && w_at_last && (r_ahead == '0) &&
                                 w_epop[NSTAGES-1] && (bus.data_out != r_tag));

endmodule
